// File: rtl/tcp_rx_pkg.sv
// Shared types for the TCP receive segment parser: FSM states, flag bit
// positions, drop reason codes and the fixed header size.
package tcp_rx_pkg;

    typedef enum logic [2:0] {
        S_HDR,
        S_OPT,
        S_PAYLOAD,
        S_EMIT,
        S_DROP
    } state_t;

    localparam int FLG_FIN = 0;
    localparam int FLG_SYN = 1;
    localparam int FLG_RST = 2;
    localparam int FLG_PSH = 3;
    localparam int FLG_ACK = 4;
    localparam int FLG_URG = 5;

    typedef enum logic [1:0] {
        ERR_SHORT   = 2'd0,
        ERR_DOFF    = 2'd1,
        ERR_OVERLEN = 2'd2,
        ERR_CSUM    = 2'd3
    } err_code_t;

    localparam int TCP_MIN_HDR_BYTES = 20;

endpackage

// File: rtl/tcp_csum_acc.sv
// Byte-wise 16-bit ones'-complement accumulator. Even-indexed bytes land in the
// high half, odd-indexed in the low half, so a trailing odd byte is zero padded.
module tcp_csum_acc (
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [15:0] seed,
    input  logic [7:0]  data,
    output logic [15:0] sum_next
);

    logic [15:0] acc;
    logic        odd;
    logic [15:0] base;
    logic        phase;
    logic [15:0] addend;
    logic [16:0] raw;

    // init restarts the sum from the seed on the first byte of a segment
    assign base     = init ? seed : acc;
    assign phase    = init ? 1'b0 : odd;
    assign addend   = phase ? {8'h00, data} : {data, 8'h00};
    assign raw      = {1'b0, base} + {1'b0, addend};
    assign sum_next = raw[15:0] + {15'd0, raw[16]};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= 16'd0;
            odd <= 1'b0;
        end else if (en) begin
            acc <= sum_next;
            odd <= ~phase;
        end
    end

endmodule

// File: rtl/tcp_rx_segment_parser.sv
// TCP receive header parser: one result pulse per good segment, one error pulse per dropped one.
// Optional checksum verification under TCP_RX_CSUM_EN.
module tcp_rx_segment_parser
    import tcp_rx_pkg::*;
#(
    parameter int MAX_SEG_BYTES = 1500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data_in,
    input  logic        rx_valid_in,
    input  logic        rx_last_in,
    output logic        rx_ready_out,
    input  logic [15:0] pseudo_sum_in,
    input  logic [15:0] local_port,
    input  logic [15:0] remote_port,
    output logic        seg_vld_out,
    output logic [15:0] src_port_out,
    output logic [15:0] dst_port_out,
    output logic [31:0] seq_out,
    output logic [31:0] ack_num_out,
    output logic [5:0]  flags_out,
    output logic [15:0] payload_len_out,
    output logic        SYN_port_vld,
    output logic        ACK_port_vld,
    output logic        FIN_out,
    output logic        RST_out,
    output logic        err_out,
    output logic [1:0]  err_code_out
);

    localparam logic [10:0] HDR_LAST = 11'(TCP_MIN_HDR_BYTES - 1);
    localparam logic [11:0] MAX_W    = 12'(MAX_SEG_BYTES);

    state_t      state, state_n;
    logic [10:0] cnt, cnt_n, cnt_inc, opt_last;
    logic [3:0]  doff;
    logic [15:0] w_src, w_dst, pl;
    logic [31:0] w_seq, w_ack;
    logic [5:0]  w_flags;
    err_code_t   drop_code, drop_code_n, fire_code, det_code;
    logic        acc, det, go_emit, err_fire, csum_bad;

    assign rx_ready_out = !rst && (state != S_EMIT);
    assign acc          = rx_valid_in && rx_ready_out;
    assign cnt_inc      = cnt + 11'd1;
    assign opt_last     = {5'd0, doff, 2'b00} - 11'd1;

`ifdef TCP_RX_CSUM_EN
    logic [15:0] csum_next;

    tcp_csum_acc u_csum (
        .clk      (clk),
        .rst      (rst),
        .init     (state == S_HDR && cnt == 11'd0),
        .en       (acc),
        .seed     (pseudo_sum_in),
        .data     (rx_data_in),
        .sum_next (csum_next)
    );

    assign csum_bad = (csum_next != 16'hFFFF);
`else
    logic unused_pseudo;
    assign unused_pseudo = ^pseudo_sum_in;
    assign csum_bad      = 1'b0;
`endif

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        drop_code_n = drop_code;
        fire_code   = drop_code;
        err_fire    = 1'b0;
        go_emit     = 1'b0;
        det         = 1'b0;
        det_code    = ERR_SHORT;
        if (state == S_EMIT) begin
            state_n = S_HDR;
        end else if (acc) begin
            cnt_n = cnt_inc;
            case (state)
                S_HDR: begin
                    if (cnt == 11'd12 && rx_data_in[7:4] < 4'd5) begin
                        det      = 1'b1;
                        det_code = ERR_DOFF;
                    end else if (cnt == HDR_LAST) begin
                        if (doff == 4'd5) begin
                            if (rx_last_in) go_emit = 1'b1;
                            else            state_n = S_PAYLOAD;
                        end else if (rx_last_in) begin
                            det = 1'b1;
                        end else begin
                            state_n = S_OPT;
                        end
                    end else if (rx_last_in) begin
                        det = 1'b1;
                    end
                end
                S_OPT: begin
                    if (cnt == opt_last) begin
                        if (rx_last_in) go_emit = 1'b1;
                        else            state_n = S_PAYLOAD;
                    end else if (rx_last_in) begin
                        det = 1'b1;
                    end
                end
                S_PAYLOAD: begin
                    if (rx_last_in) go_emit = 1'b1;
                end
                S_DROP: begin
                    if (rx_last_in) begin
                        err_fire = 1'b1;
                        state_n  = S_HDR;
                        cnt_n    = 11'd0;
                    end
                end
                default: ;
            endcase
            // Length and checksum faults override whatever the header walk decided
            if (state != S_DROP && {1'b0, cnt_inc} > MAX_W) begin
                det      = 1'b1;
                det_code = ERR_OVERLEN;
                go_emit  = 1'b0;
            end
            if (go_emit && csum_bad) begin
                det      = 1'b1;
                det_code = ERR_CSUM;
                go_emit  = 1'b0;
            end
            if (det) begin
                if (rx_last_in) begin
                    err_fire  = 1'b1;
                    fire_code = det_code;
                    state_n   = S_HDR;
                    cnt_n     = 11'd0;
                end else begin
                    state_n     = S_DROP;
                    drop_code_n = det_code;
                end
            end else if (go_emit) begin
                state_n = S_EMIT;
                cnt_n   = 11'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_HDR;
            cnt             <= 11'd0;
            drop_code       <= ERR_SHORT;
            doff            <= 4'd0;
            w_src           <= 16'd0;
            w_dst           <= 16'd0;
            w_seq           <= 32'd0;
            w_ack           <= 32'd0;
            w_flags         <= 6'd0;
            pl              <= 16'd0;
            src_port_out    <= 16'd0;
            dst_port_out    <= 16'd0;
            seq_out         <= 32'd0;
            ack_num_out     <= 32'd0;
            flags_out       <= 6'd0;
            payload_len_out <= 16'd0;
            err_out         <= 1'b0;
            err_code_out    <= 2'd0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            drop_code <= drop_code_n;
            err_out   <= err_fire;
            if (err_fire) err_code_out <= fire_code;

            if (acc && state == S_HDR) begin
                case (cnt)
                    11'd0, 11'd1:                 w_src <= {w_src[7:0], rx_data_in};
                    11'd2, 11'd3:                 w_dst <= {w_dst[7:0], rx_data_in};
                    11'd4, 11'd5, 11'd6, 11'd7:   w_seq <= {w_seq[23:0], rx_data_in};
                    11'd8, 11'd9, 11'd10, 11'd11: w_ack <= {w_ack[23:0], rx_data_in};
                    11'd12:                       doff <= rx_data_in[7:4];
                    11'd13:                       w_flags <= rx_data_in[5:0];
                    default: ;
                endcase
            end

            if (state == S_HDR)                     pl <= 16'd0;
            else if (acc && state == S_PAYLOAD)     pl <= pl + 16'd1;

            // Result fields change only when a segment is committed
            if (go_emit && !det) begin
                src_port_out    <= w_src;
                dst_port_out    <= w_dst;
                seq_out         <= w_seq;
                ack_num_out     <= w_ack;
                flags_out       <= w_flags;
                payload_len_out <= (state == S_PAYLOAD) ? pl + 16'd1 : 16'd0;
            end
        end
    end

    logic dst_ok, conn_ok;
    assign dst_ok  = (dst_port_out == local_port);
    assign conn_ok = dst_ok && (src_port_out == remote_port);

    assign seg_vld_out  = (state == S_EMIT);
    assign SYN_port_vld = seg_vld_out && flags_out[FLG_SYN] && !flags_out[FLG_ACK] && dst_ok;
    assign ACK_port_vld = seg_vld_out && flags_out[FLG_ACK] && !flags_out[FLG_SYN] && conn_ok;
    assign FIN_out      = seg_vld_out && flags_out[FLG_FIN] && conn_ok;
    assign RST_out      = seg_vld_out && flags_out[FLG_RST] && conn_ok;

endmodule

// File: tb/tb_tcp_rx_segment_parser.sv
// Directed bench for tcp_rx_segment_parser; checksum scenario built when TCP_RX_CSUM_EN is defined.
module tb_tcp_rx_segment_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data_in = 8'h00;
    logic        rx_valid_in = 1'b0;
    logic        rx_last_in = 1'b0;
    logic        rx_ready_out;
    logic [15:0] pseudo_sum_in = 16'h1234;
    logic [15:0] local_port = 16'h0050;
    logic [15:0] remote_port = 16'hC000;
    logic        seg_vld_out;
    logic [15:0] src_port_out, dst_port_out, payload_len_out;
    logic [31:0] seq_out, ack_num_out;
    logic [5:0]  flags_out;
    logic        SYN_port_vld, ACK_port_vld, FIN_out, RST_out;
    logic        err_out;
    logic [1:0]  err_code_out;

    tcp_rx_segment_parser #(.MAX_SEG_BYTES(1500)) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_data_in      (rx_data_in),
        .rx_valid_in     (rx_valid_in),
        .rx_last_in      (rx_last_in),
        .rx_ready_out    (rx_ready_out),
        .pseudo_sum_in   (pseudo_sum_in),
        .local_port      (local_port),
        .remote_port     (remote_port),
        .seg_vld_out     (seg_vld_out),
        .src_port_out    (src_port_out),
        .dst_port_out    (dst_port_out),
        .seq_out         (seq_out),
        .ack_num_out     (ack_num_out),
        .flags_out       (flags_out),
        .payload_len_out (payload_len_out),
        .SYN_port_vld    (SYN_port_vld),
        .ACK_port_vld    (ACK_port_vld),
        .FIN_out         (FIN_out),
        .RST_out         (RST_out),
        .err_out         (err_out),
        .err_code_out    (err_code_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] seg_q[$];
    int acc_cyc;

    int vld_cnt, err_cnt, nrdy_cnt, vld_cyc, err_cyc, overlap_cnt, stray_cnt;
    logic syn_s, ack_s, fin_s, rst_s;
    logic [1:0] code_c;

    always @(negedge clk) begin
        if (!rst) begin
            if (seg_vld_out) begin
                vld_cnt++;
                vld_cyc = cyc;
                syn_s = SYN_port_vld;
                ack_s = ACK_port_vld;
                fin_s = FIN_out;
                rst_s = RST_out;
            end
            if (err_out) begin
                err_cnt++;
                err_cyc = cyc;
                code_c  = err_code_out;
            end
            if (err_out && (seg_vld_out || SYN_port_vld || ACK_port_vld || FIN_out || RST_out))
                overlap_cnt++;
            if (!seg_vld_out && (SYN_port_vld || ACK_port_vld || FIN_out || RST_out))
                stray_cnt++;
            if (!rx_ready_out) nrdy_cnt++;
        end
    end

    task automatic clear_mon();
        vld_cnt = 0; err_cnt = 0; nrdy_cnt = 0; vld_cyc = -1; err_cyc = -1;
        syn_s = 0; ack_s = 0; fin_s = 0; rst_s = 0; code_c = 2'd0;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic build_hdr(input logic [15:0] src, input logic [15:0] dst, input logic [31:0] seq,
                             input logic [31:0] ack, input logic [3:0] doff, input logic [5:0] flags);
        seg_q.delete();
        seg_q.push_back(src[15:8]); seg_q.push_back(src[7:0]);
        seg_q.push_back(dst[15:8]); seg_q.push_back(dst[7:0]);
        for (int i = 3; i >= 0; i--) seg_q.push_back(seq[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) seg_q.push_back(ack[i*8 +: 8]);
        seg_q.push_back({doff, 4'h0});
        seg_q.push_back({2'b00, flags});
        seg_q.push_back(8'h10); seg_q.push_back(8'h00);
        seg_q.push_back(8'h00); seg_q.push_back(8'h00);
        seg_q.push_back(8'h00); seg_q.push_back(8'h00);
    endtask

    task automatic add_bytes(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) seg_q.push_back(base + 8'(i));
    endtask

`ifdef TCP_RX_CSUM_EN
    function automatic logic [15:0] word_sum(input logic [15:0] seed);
        logic [31:0] s;
        logic [15:0] w;
        s = {16'h0, seed};
        for (int i = 0; i < seg_q.size(); i += 2) begin
            w = {seg_q[i], 8'h00};
            if (i + 1 < seg_q.size()) w[7:0] = seg_q[i+1];
            s = s + {16'h0, w};
        end
        while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        return s[15:0];
    endfunction
`endif

    task automatic send_byte(input logic [7:0] d, input logic l);
        int guard = 0;
        rx_valid_in = 1'b1; rx_data_in = d; rx_last_in = l;
        @(negedge clk);
        while (!rx_ready_out && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        if (!rx_ready_out) begin
            vectors++; miscompares++;
            $display("FAIL ready_timeout: rx_ready_out stayed 0 for %0d cycles, required 1", guard);
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        rx_valid_in = 1'b0; rx_last_in = 1'b0;
    endtask

    task automatic send_seg(input bit gaps, input bit corrupt);
        logic [15:0] s;
        s = 16'h0;
`ifdef TCP_RX_CSUM_EN
        if (seg_q.size() >= 18) begin
            seg_q[16] = 8'h00; seg_q[17] = 8'h00;
            s = ~word_sum(pseudo_sum_in);
            seg_q[16] = s[15:8]; seg_q[17] = s[7:0];
        end
`endif
        if (corrupt) seg_q[seg_q.size()-1] = seg_q[seg_q.size()-1] ^ 8'h04;
        for (int i = 0; i < seg_q.size(); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                rx_valid_in = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send_byte(seg_q[i], i == seg_q.size() - 1);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (rx_ready_out !== 1'b0) begin miscompares++; $display("FAIL rst_ready got %b exp 0", rx_ready_out); end
        vectors++; if (seg_vld_out !== 1'b0 || err_out !== 1'b0) begin miscompares++; $display("FAIL rst_pulses got vld=%b err=%b exp 0 0", seg_vld_out, err_out); end
        vectors++; if (seq_out !== 32'h0 || src_port_out !== 16'h0 || flags_out !== 6'h0 || payload_len_out !== 16'h0) begin
            miscompares++; $display("FAIL rst_fields got seq=%h src=%h flags=%h len=%h exp all 0", seq_out, src_port_out, flags_out, payload_len_out); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (rx_ready_out !== 1'b1) begin miscompares++; $display("FAIL idle_ready got %b exp 1", rx_ready_out); end
        @(posedge clk); #1;
    endtask

    task automatic test_syn();
        clear_mon();
        build_hdr(16'h1234, 16'h0050, 32'hDEADBEEF, 32'h0, 4'd5, 6'h02);
        send_seg(1'b0, 1'b0);
        settle();
        vectors++; if (vld_cnt !== 1 || vld_cyc !== acc_cyc) begin miscompares++; $display("FAIL syn_vld got cnt=%0d cyc=%0d exp 1 at %0d", vld_cnt, vld_cyc, acc_cyc); end
        vectors++; if (syn_s !== 1'b1 || ack_s !== 1'b0) begin miscompares++; $display("FAIL syn_strobes got syn=%b ack=%b exp 1 0", syn_s, ack_s); end
        vectors++; if (seq_out !== 32'hDEADBEEF) begin miscompares++; $display("FAIL syn_seq got %h exp deadbeef", seq_out); end
        vectors++; if (src_port_out !== 16'h1234 || dst_port_out !== 16'h0050) begin miscompares++; $display("FAIL syn_ports got %h %h exp 1234 0050", src_port_out, dst_port_out); end
        vectors++; if (payload_len_out !== 16'd0 || flags_out !== 6'h02) begin miscompares++; $display("FAIL syn_len_flags got %0d %h exp 0 02", payload_len_out, flags_out); end
        vectors++; if (nrdy_cnt !== 1 || err_cnt !== 0) begin miscompares++; $display("FAIL syn_ready_err got nrdy=%0d err=%0d exp 1 0", nrdy_cnt, err_cnt); end
    endtask

    task automatic test_ack_fin();
        clear_mon();
        build_hdr(16'hC000, 16'h0050, 32'h1, 32'h01020304, 4'd5, 6'h11);
        add_bytes(3, 8'hA0);
        send_seg(1'b0, 1'b0);
        settle();
        vectors++; if (ack_s !== 1'b1 || fin_s !== 1'b1 || syn_s !== 1'b0 || rst_s !== 1'b0) begin
            miscompares++; $display("FAIL ackfin_strobes got ack=%b fin=%b syn=%b rst=%b exp 1 1 0 0", ack_s, fin_s, syn_s, rst_s); end
        vectors++; if (ack_num_out !== 32'h01020304 || payload_len_out !== 16'd3) begin
            miscompares++; $display("FAIL ackfin_fields got ack=%h len=%0d exp 01020304 3", ack_num_out, payload_len_out); end
        clear_mon();
        build_hdr(16'hC001, 16'h0050, 32'h2, 32'h5, 4'd5, 6'h11);
        send_seg(1'b0, 1'b0);
        settle();
        vectors++; if (vld_cnt !== 1 || ack_s !== 1'b0 || fin_s !== 1'b0) begin
            miscompares++; $display("FAIL ackfin_wrong_src got vld=%0d ack=%b fin=%b exp 1 0 0", vld_cnt, ack_s, fin_s); end
        clear_mon();
        build_hdr(16'hC000, 16'h0050, 32'h3, 32'h6, 4'd5, 6'h14);
        send_seg(1'b0, 1'b0);
        settle();
        vectors++; if (rst_s !== 1'b1 || ack_s !== 1'b1 || fin_s !== 1'b0) begin
            miscompares++; $display("FAIL rst_strobe got rst=%b ack=%b fin=%b exp 1 1 0", rst_s, ack_s, fin_s); end
    endtask

    task automatic test_options();
        clear_mon();
        build_hdr(16'hC000, 16'h0050, 32'h100, 32'h200, 4'd7, 6'h18);
        add_bytes(8, 8'h01);
        add_bytes(10, 8'h40);
        send_seg(1'b1, 1'b0);
        settle();
        vectors++; if (vld_cnt !== 1 || vld_cyc !== acc_cyc) begin miscompares++; $display("FAIL opt_vld got cnt=%0d cyc=%0d exp 1 at %0d", vld_cnt, vld_cyc, acc_cyc); end
        vectors++; if (payload_len_out !== 16'd10 || flags_out !== 6'h18) begin miscompares++; $display("FAIL opt_len_flags got %0d %h exp 10 18", payload_len_out, flags_out); end
        vectors++; if (ack_s !== 1'b1 || seq_out !== 32'h100) begin miscompares++; $display("FAIL opt_ack_seq got %b %h exp 1 00000100", ack_s, seq_out); end
    endtask

    task automatic test_errors();
        clear_mon();
        build_hdr(16'hC000, 16'h0050, 32'h7, 32'h8, 4'd5, 6'h10);
        seg_q = seg_q[0:11];
        send_seg(1'b0, 1'b0);
        settle();
        vectors++; if (err_cnt !== 1 || code_c !== 2'd0 || err_cyc !== acc_cyc || vld_cnt !== 0) begin
            miscompares++; $display("FAIL short_err got err=%0d code=%0d cyc=%0d vld=%0d exp 1 0 %0d 0", err_cnt, code_c, err_cyc, vld_cnt, acc_cyc); end
        clear_mon();
        build_hdr(16'hC000, 16'h0050, 32'h7, 32'h8, 4'd3, 6'h10);
        send_seg(1'b0, 1'b0);
        settle();
        vectors++; if (err_cnt !== 1 || code_c !== 2'd1 || err_cyc !== acc_cyc || vld_cnt !== 0) begin
            miscompares++; $display("FAIL doff_err got err=%0d code=%0d cyc=%0d vld=%0d exp 1 1 %0d 0", err_cnt, code_c, err_cyc, vld_cnt, acc_cyc); end
        clear_mon();
        build_hdr(16'hC000, 16'h0050, 32'h7, 32'h8, 4'd6, 6'h10);
        send_seg(1'b0, 1'b0);
        settle();
        vectors++; if (err_cnt !== 1 || code_c !== 2'd0 || vld_cnt !== 0) begin
            miscompares++; $display("FAIL trunc_opt_err got err=%0d code=%0d vld=%0d exp 1 0 0", err_cnt, code_c, vld_cnt); end
        vectors++; if (seq_out !== 32'h100) begin miscompares++; $display("FAIL hold_after_err got %h exp 00000100", seq_out); end
    endtask

    task automatic test_overlength();
        clear_mon();
        build_hdr(16'hC000, 16'h0050, 32'h9, 32'hA, 4'd5, 6'h10);
        add_bytes(1480, 8'h00);
        send_seg(1'b0, 1'b0);
        settle();
        vectors++; if (vld_cnt !== 1 || payload_len_out !== 16'd1480) begin
            miscompares++; $display("FAIL max_len got vld=%0d len=%0d exp 1 1480", vld_cnt, payload_len_out); end
        clear_mon();
        build_hdr(16'hC000, 16'h0050, 32'hB, 32'hC, 4'd5, 6'h10);
        add_bytes(1481, 8'h00);
        send_seg(1'b0, 1'b0);
        settle();
        vectors++; if (err_cnt !== 1 || code_c !== 2'd2 || err_cyc !== acc_cyc || vld_cnt !== 0) begin
            miscompares++; $display("FAIL overlen got err=%0d code=%0d cyc=%0d vld=%0d exp 1 2 %0d 0", err_cnt, code_c, err_cyc, vld_cnt, acc_cyc); end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        build_hdr(16'hC000, 16'h0050, 32'h11, 32'h12, 4'd5, 6'h10);
        add_bytes(2, 8'h55);
        send_seg(1'b0, 1'b0);
        build_hdr(16'hC000, 16'h0050, 32'h22, 32'h23, 4'd5, 6'h10);
        send_seg(1'b0, 1'b0);
        settle();
        vectors++; if (vld_cnt !== 2 || nrdy_cnt !== 2) begin
            miscompares++; $display("FAIL b2b got vld=%0d nrdy=%0d exp 2 2", vld_cnt, nrdy_cnt); end
        vectors++; if (seq_out !== 32'h22 || payload_len_out !== 16'd0) begin
            miscompares++; $display("FAIL b2b_second got seq=%h len=%0d exp 00000022 0", seq_out, payload_len_out); end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        build_hdr(16'hC000, 16'h0050, 32'h33, 32'h34, 4'd5, 6'h10);
        for (int i = 0; i < 9; i++) send_byte(seg_q[i], 1'b0);
        rst = 1'b1; rx_valid_in = 1'b1; rx_data_in = seg_q[9];
        @(negedge clk);
        vectors++; if (rx_ready_out !== 1'b0) begin miscompares++; $display("FAIL mid_rst_ready got %b exp 0", rx_ready_out); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; rx_valid_in = 1'b0;
        build_hdr(16'h4321, 16'h0050, 32'h44, 32'h0, 4'd5, 6'h02);
        send_seg(1'b0, 1'b0);
        settle();
        vectors++; if (vld_cnt !== 1 || err_cnt !== 0 || syn_s !== 1'b1) begin
            miscompares++; $display("FAIL mid_rst got vld=%0d err=%0d syn=%b exp 1 0 1", vld_cnt, err_cnt, syn_s); end
        vectors++; if (seq_out !== 32'h44 || src_port_out !== 16'h4321) begin
            miscompares++; $display("FAIL mid_rst_fields got seq=%h src=%h exp 00000044 4321", seq_out, src_port_out); end
    endtask

`ifdef TCP_RX_CSUM_EN
    task automatic test_csum();
        clear_mon();
        build_hdr(16'hC000, 16'h0050, 32'h55, 32'h56, 4'd5, 6'h18);
        add_bytes(5, 8'h61);
        send_seg(1'b0, 1'b0);
        settle();
        vectors++; if (vld_cnt !== 1 || err_cnt !== 0) begin miscompares++; $display("FAIL csum_good got vld=%0d err=%0d exp 1 0", vld_cnt, err_cnt); end
        clear_mon();
        send_seg(1'b0, 1'b1);
        settle();
        vectors++; if (err_cnt !== 1 || code_c !== 2'd3 || vld_cnt !== 0) begin
            miscompares++; $display("FAIL csum_bad got err=%0d code=%0d vld=%0d exp 1 3 0", err_cnt, code_c, vld_cnt); end
    endtask
`endif

    initial begin
        overlap_cnt = 0;
        stray_cnt = 0;
        clear_mon();
        test_reset();
        test_syn();
        test_ack_fin();
        test_options();
        test_errors();
        test_overlength();
        test_back_to_back();
        test_reset_mid();
`ifdef TCP_RX_CSUM_EN
        test_csum();
`endif
        vectors++; if (overlap_cnt !== 0 || stray_cnt !== 0) begin
            miscompares++; $display("FAIL strobe_exclusive got overlap=%0d stray=%0d exp 0 0", overlap_cnt, stray_cnt); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tcp_rx_segment_parser.md
# tcp_rx_segment_parser

Receive-side TCP segment parser that sits directly upstream of the TCP server connection FSM. It consumes a byte stream of TCP segments delivered by the IP receive stage and extracts the header fields. Once per segment it emits a one-cycle result containing the flags, port numbers and sequence fields, plus port-qualified strobes (SYN/ACK/FIN/RST) that the connection FSM consumes directly. Malformed segments are dropped and reported with an error code.

## Interface
- MAX_SEG_BYTES, 1500, maximum total segment length in bytes (header plus payload); longer segments are dropped.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rx_data_in  in  8  segment byte, network order
- rx_valid_in  in  1  byte valid
- rx_last_in  in  1  last byte of segment, qualified by rx_valid_in
- rx_ready_out  out  1  byte accepted when rx_valid_in && rx_ready_out
- pseudo_sum_in  in  16  IP pseudo-header ones'-complement partial sum, sampled with the first byte; used only under the macro
- local_port  in  16  port the server listens on
- remote_port  in  16  peer port of the current connection
- seg_vld_out  out  1  one-cycle pulse: a segment was parsed successfully
- src_port_out, dst_port_out  out  16  header ports
- seq_out, ack_num_out  out  32  sequence and acknowledgement numbers
- flags_out  out  6  {URG,ACK,PSH,RST,SYN,FIN}
- payload_len_out  out  16  payload bytes after options
- SYN_port_vld  out  1  seg_vld && SYN && !ACK && dst==local_port
- ACK_port_vld  out  1  seg_vld && ACK && !SYN && dst==local_port && src==remote_port
- FIN_out, RST_out  out  1  seg_vld && flag && ports match as for ACK_port_vld
- err_out  out  1  one-cycle pulse: segment dropped
- err_code_out  out  2  0 short header, 1 bad data offset, 2 overlength, 3 checksum

## Operation
- States: HDR, OPT, PAYLOAD, EMIT, DROP. Reset state is HDR with byte counter 0.
- HDR: the 11-bit byte counter indexes bytes 0..19.
  - Bytes 0-1 are src port, 2-3 dst port, 4-7 seq, 8-11 ack.
  - Byte 12[7:4] is the data offset (doff); byte 13[5:0] is the flags.
  - At byte 12: if doff<5, go to DROP with code 1.
  - At byte 19: if doff==5, go to PAYLOAD; otherwise go to OPT.
- OPT: discard bytes until the counter reaches doff*4-1, then go to PAYLOAD.
- PAYLOAD: increment payload_len per accepted byte; the data is discarded.
- rx_last_in is evaluated in every state:
  - In HDR before byte 19, or in OPT before the end of options: err code 0, no seg_vld.
  - On the accepted last byte, with no error: go to EMIT.
- If the total count exceeds MAX_SEG_BYTES, go to DROP with code 2.
- DROP: accept and discard bytes until rx_last_in, then pulse err_out and return to HDR. If the error is detected on a last byte, err_out pulses the next cycle.
- EMIT: one cycle. seg_vld_out and the qualified strobes pulse, then the block returns to HDR.
- Output fields are registered, update only in EMIT, and hold until the next EMIT. Reset values are all 0.
- Reset mid-segment: the partial segment is discarded and no pulse is produced. The following bytes are parsed as the start of a new segment.

## Timing
- rx_ready_out is 1 in every state except EMIT, where it is 0. rx_ready_out is 0 while rst is asserted.
- Latency: seg_vld_out is asserted exactly one cycle after the cycle that accepts the last byte.
- Back-to-back segments cost one bubble cycle (EMIT).
- err_out is asserted one cycle after the accepted last byte of the dropped segment.
- The qualified strobes are cycle-aligned with seg_vld_out and are never asserted together with err_out.
- rx_valid_in gaps are allowed in any state; the counter advances only on an accepted byte.

## Configuration
- TCP_RX_CSUM_EN defined:
  - 16-bit ones'-complement end-around-carry accumulator over all segment bytes, seeded with pseudo_sum_in. An odd trailing byte is padded with 0x00.
  - At the last byte, a final sum not equal to 16'hFFFF drops the segment: err code 3, no seg_vld.
- TCP_RX_CSUM_EN undefined: no accumulator is built, pseudo_sum_in is ignored, and error code 3 never occurs.

## Structure
- Shared package tcp_rx_pkg contains:
  - the state enum;
  - the flag bit indices (FIN=0..URG=5);
  - the error code enum;
  - TCP_MIN_HDR_BYTES=20.
- One sub-module, tcp_csum_acc: byte-wise ones'-complement accumulator with init, enable and odd-byte handling. It is instantiated only under TCP_RX_CSUM_EN.

## Test plan
- SYN segment, src=0x1234, dst=local_port=0x0050, seq=0xDEADBEEF, doff=5, no payload -> one cycle after last: SYN_port_vld=1, seq_out=0xDEADBEEF, payload_len_out=0.
- ACK|FIN segment with src=remote_port and dst=local_port -> ACK_port_vld=1 and FIN_out=1. Same segment with src≠remote_port -> seg_vld_out=1, ACK_port_vld=0, FIN_out=0.
- doff=7 with 8 option bytes and 10 payload bytes, with random valid gaps -> payload_len_out=10 and flags correct.
- 12-byte segment ending on rx_last_in -> err_out with code 0 and no seg_vld. A segment with doff=3 -> err_out with code 1 after its last byte.
- Two segments back-to-back -> two seg_vld pulses, with rx_ready_out=0 for exactly one cycle between them. rst asserted at byte 9 of a segment -> no pulse, and the next segment parses correctly.
- With TCP_RX_CSUM_EN: a correct segment gives seg_vld_out. The same segment with one payload bit flipped gives err_out with code 3.
